// File: rtl/toggle_request_queue.sv
// Serializes up to two toggle requests per cycle into one toggle per cycle.
// Same-ID request pairs cancel; storage is a small flop-based circular FIFO.
module toggle_request_queue #(
    parameter  int DEPTH       = 8,
    parameter  int QUEUE_DEPTH = 4,
    localparam int IDW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int PW          = $clog2(QUEUE_DEPTH),
    localparam int CW          = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_a_valid,
    input  logic [IDW-1:0] req_a_id,
    input  logic           req_b_valid,
    input  logic [IDW-1:0] req_b_id,
    output logic           req_ready,
    output logic           toggle,
    output logic [IDW-1:0] toggle_id,
    output logic [CW-1:0]  pending_count,
    output logic           empty
);

    logic [IDW-1:0] r_mem [QUEUE_DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic           w_pop;
    logic           w_pair;
    logic           w_one;
    logic [1:0]     w_npush;
    logic [IDW-1:0] w_first_id;
    logic [PW-1:0]  w_wr_ptr_p1;

    // Readiness looks only at registered occupancy, so two slots are always free.
    assign req_ready = (r_count <= CW'(QUEUE_DEPTH - 2));
    assign w_pop     = (r_count != '0);
    assign w_wr_ptr_p1 = r_wr_ptr + PW'(1);

    always_comb begin
        w_pair     = 1'b0;
        w_one      = 1'b0;
        w_npush    = 2'd0;
        w_first_id = req_a_id;
        if (req_ready) begin
            if (req_a_valid && req_b_valid) begin
                w_pair = (req_a_id != req_b_id);
            end else if (req_a_valid) begin
                w_one = 1'b1;
            end else if (req_b_valid) begin
                w_one      = 1'b1;
                w_first_id = req_b_id;
            end
        end
        if (w_pair) begin
            w_npush = 2'd2;
        end else if (w_one) begin
            w_npush = 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_npush != 2'd0) begin
            r_mem[r_wr_ptr] <= w_first_id;
        end
        if (w_pair) begin
            r_mem[w_wr_ptr_p1] <= req_b_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_npush);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_count  <= r_count + CW'(w_npush) - CW'(w_pop);
        end
    end

    assign toggle        = w_pop;
    assign toggle_id     = w_pop ? r_mem[r_rd_ptr] : '0;
    assign pending_count = r_count;
    assign empty         = !w_pop;

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (rst) (w_npush != 2'd0) |-> req_ready);

    a_count_bound: assert property (
        @(posedge clk) disable iff (rst) r_count <= CW'(QUEUE_DEPTH));

endmodule

// File: tb/tb_toggle_request_queue.sv
// Directed and random checks for toggle_request_queue against a queue model.
module tb_toggle_request_queue;

    localparam int DEPTH = 8;
    localparam int QD    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a_valid = 1'b0;
    logic [2:0] req_a_id = '0;
    logic       req_b_valid = 1'b0;
    logic [2:0] req_b_id = '0;
    logic       req_ready;
    logic       toggle;
    logic [2:0] toggle_id;
    logic [2:0] pending_count;
    logic       empty;

    int n_tests = 0;
    int n_fail  = 0;
    int n_proto = 0;

    logic [2:0] mq[$];
    logic [7:0] par_exp = '0;
    logic [7:0] par_obs = '0;

    toggle_request_queue #(.DEPTH(DEPTH), .QUEUE_DEPTH(QD)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_a_valid  (req_a_valid),
        .req_a_id     (req_a_id),
        .req_b_valid  (req_b_valid),
        .req_b_id     (req_b_id),
        .req_ready    (req_ready),
        .toggle       (toggle),
        .toggle_id    (toggle_id),
        .pending_count(pending_count),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive one cycle, step the model, recheck at next negedge.
    task automatic cyc(input logic a, input logic [2:0] ia,
                       input logic b, input logic [2:0] ib);
        bit rdy;
        rdy = (mq.size() <= QD - 2);
        check("ready", req_ready, rdy);
        if (toggle) par_obs[toggle_id] ^= 1'b1;
        if ((a || b) && !rdy) n_proto++;
        req_a_valid = a; req_a_id = ia;
        req_b_valid = b; req_b_id = ib;
        @(posedge clk);
        if (mq.size() != 0) void'(mq.pop_front());
        if (rdy) begin
            if (a) par_exp[ia] ^= 1'b1;
            if (b) par_exp[ib] ^= 1'b1;
            if (a && b) begin
                if (ia != ib) begin
                    mq.push_back(ia);
                    mq.push_back(ib);
                end
            end else if (a) begin
                mq.push_back(ia);
            end else if (b) begin
                mq.push_back(ib);
            end
        end
        @(negedge clk);
        req_a_valid = 1'b0;
        req_b_valid = 1'b0;
        check("count", pending_count, mq.size());
        check("toggle", toggle, mq.size() != 0);
        check("empty", empty, mq.size() == 0);
        if (mq.size() != 0) check("tid", toggle_id, mq[0]);
    endtask

    task automatic drain();
        for (int i = 0; i < QD + 1; i++) cyc(0, 0, 0, 0);
    endtask

    logic [2:0] k;

    initial begin
        #2;
        check("rst_toggle", toggle, 0);
        check("rst_count", pending_count, 0);
        check("rst_empty", empty, 1);
        check("rst_ready", req_ready, 1);
        check("rst_tid", toggle_id, 0);
        @(negedge clk);
        rst = 1'b0;

        // single A request
        cyc(1, 3, 0, 0);
        check("a3_tog", toggle, 1);
        check("a3_tid", toggle_id, 3);
        check("a3_cnt", pending_count, 1);
        cyc(0, 0, 0, 0);
        check("a3_tog_off", toggle, 0);
        check("a3_empty", empty, 1);

        // ordered pair
        cyc(1, 2, 1, 5);
        check("p_tid0", toggle_id, 2);
        check("p_cnt0", pending_count, 2);
        cyc(0, 0, 0, 0);
        check("p_tid1", toggle_id, 5);
        check("p_cnt1", pending_count, 1);
        cyc(0, 0, 0, 0);
        check("p_cnt2", pending_count, 0);

        // same-ID cancel
        cyc(1, 4, 1, 4);
        check("c_tog0", toggle, 0);
        check("c_cnt0", pending_count, 0);
        cyc(0, 0, 0, 0);
        check("c_tog1", toggle, 0);

        // back-to-back dual pushes with pointer wrap
        cyc(1, 0, 1, 1);
        check("f_cnt2", pending_count, 2);
        check("f_rdy2", req_ready, 1);
        cyc(1, 2, 1, 3);
        check("f_cnt3", pending_count, 3);
        check("f_rdy3", req_ready, 0);
        k = 3'd4;
        for (int i = 0; i < 12; i++) begin
            if (req_ready) begin
                cyc(1, k, 1, k + 3'd1);
                k = k + 3'd2;
            end else begin
                cyc(0, 0, 0, 0);
            end
        end
        drain();

        // async reset with three pending entries
        cyc(1, 0, 1, 1);
        cyc(1, 2, 1, 3);
        check("r_cnt3", pending_count, 3);
        #2 rst = 1'b1;
        #1;
        check("r_async_tog", toggle, 0);
        check("r_async_cnt", pending_count, 0);
        check("r_async_rdy", req_ready, 1);
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 7, 0, 0);
        check("r_tid7", toggle_id, 7);
        drain();

        // random legal traffic with parity tracking
        par_exp = '0;
        par_obs = '0;
        for (int i = 0; i < 10000; i++) begin
            if (req_ready)
                cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            else
                cyc(0, 0, 0, 0);
        end
        drain();
        for (int i = 0; i < DEPTH; i++) check("parity", par_obs[i], par_exp[i]);
        check("protocol", n_proto, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/toggle_request_queue.md
TOGGLE_REQUEST_QUEUE -- requirements
Module: toggle_request_queue

Interface
REQ-001 Parameter DEPTH, default 8: size of the ID space; ID width is $clog2(DEPTH).
REQ-002 Parameter QUEUE_DEPTH, default 4: pending-request storage entries; SHALL be a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state SHALL be updated on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_a_valid  input  1  toggle request A (issue side) this cycle.
REQ-006 req_a_id  input  $clog2(DEPTH)  ID for request A.
REQ-007 req_b_valid  input  1  toggle request B (retire side) this cycle.
REQ-008 req_b_id  input  $clog2(DEPTH)  ID for request B.
REQ-009 req_ready  output  1  queue can accept two requests this cycle.
REQ-010 toggle  output  1  drives the single toggle port of the downstream toggle memory.
REQ-011 toggle_id  output  $clog2(DEPTH)  ID to toggle; meaningful only when toggle=1.
REQ-012 pending_count  output  $clog2(QUEUE_DEPTH+1)  number of queued entries.
REQ-013 empty  output  1  pending_count==0.

Function
REQ-014 The block SHALL serialize up to two toggle requests per cycle onto one toggle per cycle, preserving order: A before B within a cycle, and older cycles before newer ones.
REQ-015 Storage SHALL be a circular FIFO of QUEUE_DEPTH entries with read and write pointers that wrap modulo QUEUE_DEPTH.
REQ-016 toggle SHALL equal !empty; toggle_id SHALL equal the head entry; there is no bypass, so a request appears on toggle exactly 1 cycle after it is accepted, when the queue was empty.
REQ-017 The head entry SHALL be popped on every cycle in which toggle=1; the downstream block has no back-pressure.
REQ-018 req_ready SHALL be 1 iff pending_count <= QUEUE_DEPTH-2; it is derived from registered state only and is independent of the current pop and push.
REQ-019 Requests presented while req_ready=0 SHALL be ignored, with no state change from them; the bench SHALL flag such a request as a protocol error.
REQ-020 If only A or only B is valid, exactly one entry SHALL be pushed.
REQ-021 If A and B are both valid with different IDs, the block SHALL push A at the write pointer and B at the write pointer +1, both modulo QUEUE_DEPTH.
REQ-022 If A and B are both valid with req_a_id==req_b_id, nothing SHALL be pushed, because two toggles of the same ID cancel.
REQ-023 pending_count next value SHALL be pending_count + pushes - pop, where pushes is 0..2 and pop is 0..1; simultaneous push and pop are legal at every occupancy.
REQ-024 Full boundary: with pending_count==QUEUE_DEPTH-1 or QUEUE_DEPTH, req_ready=0, and the FIFO SHALL NOT overflow.
REQ-025 Empty boundary: with pending_count==0, toggle=0 and no pop occurs.

Reset
REQ-026 While rst=1: pointers=0, pending_count=0, empty=1, toggle=0, req_ready=1; toggle_id SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard all pending entries immediately, without waiting for a clock edge.
REQ-028 The first push SHALL be accepted on the first rising edge after rst deasserts.
REQ-029 Storage entry contents need not be reset.

Structure
REQ-030 No shared-package additions SHALL be made; ID width SHALL be computed locally from DEPTH.
REQ-031 Storage SHALL be a flip-flop array, not LUTRAM, because two writes per cycle are needed.
REQ-032 No sub-module SHALL be instantiated; the block is a single module.
REQ-033 The block SHALL contain assertions for: push while req_ready=0; pending_count > QUEUE_DEPTH.

Verification
REQ-034 Reset, then A valid id=3 for one cycle -> next cycle toggle=1, toggle_id=3, pending_count=1; the cycle after -> toggle=0, empty=1.
REQ-035 A id=2 and B id=5 in the same cycle -> toggle_id=2, then 5, on consecutive cycles; pending_count goes 2 then 1 then 0.
REQ-036 A id=4 and B id=4 in the same cycle -> no toggle ever, pending_count stays 0.
REQ-037 Dual pushes of distinct IDs every cycle with QUEUE_DEPTH=4 -> pending_count climbs 2, 3; req_ready drops at 3; order is preserved across pointer wrap; drained IDs match the issue order.
REQ-038 rst asserted with pending_count=3 -> toggle=0 and pending_count=0 asynchronously; after release, A id=7 -> toggle_id=7 one cycle later.
REQ-039 Random A/B traffic obeying req_ready for 10k cycles, fed into a toggle memory model -> final per-ID parity equals the XOR of all accepted requests.
